vga_fb_scanout_arbiter: RTL and testbench

Shares one single-port framebuffer RAM between video scanout and CPU pixel writes. The framebuffer is 160x120 pixels at 12 bpp, and each pixel is shown as a 4x4 block on the 640x480 display. A small prefetch FIFO feeds the VGA timing block one pixel per active pixel clock. The block sits between the framebuffer RAM, the CPU bus bridge and the VGA timing/output stage.

---
 rtl/vga_fb_scanout_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_vga_fb_scanout_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scanout_arbiter.sv
// vga_fb_scanout_arbiter: one single-port framebuffer RAM shared by a scanout prefetch FIFO and CPU writes.
// Latency: RAM op one cycle after arbitration; read data enters the FIFO two cycles after arbitration.
// Backpressure: cpu_req held until cpu_ack; fetch stalls on FIFO fill; pix_rd on empty FIFO sets sticky underflow.
// Build option VGA_FB_CPU_READ_EN adds cpu_we/cpu_rdata so the CPU port can also read.

module vga_fb_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 8
) (
    input  logic                   clk_25,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_rdy,
    output logic [W-1:0]           head_dat,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop_rdy && !empty;
    assign head_dat = mem[rd_ptr];

    // No full check: the writer bounds its outstanding pushes against count.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_vld) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_25) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end
endmodule

module vga_fb_scanout_arbiter #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int LOW_WM     = 3,
    parameter int ADDR_W     = 15
) (
    input  logic              clk_25,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pix_rd,
    output logic [11:0]       pix_rgb,
    output logic              underflow,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [11:0]       cpu_data,
`ifdef VGA_FB_CPU_READ_EN
    input  logic              cpu_we,
    output logic [11:0]       cpu_rdata,
`endif
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [11:0]       ram_wdata,
    output logic              ram_we,
    input  logic [11:0]       ram_rdata
);
    localparam int SCALE = 1 << SCALE_LOG2;
    localparam int FXW   = $clog2(FB_W);
    localparam int FYW   = $clog2(FB_H);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int FW    = CW + 1;

    localparam logic [FXW-1:0]        FX_LAST   = FXW'(FB_W - 1);
    localparam logic [FYW-1:0]        FY_LAST   = FYW'(FB_H - 1);
    localparam logic [SCALE_LOG2-1:0] REP_LAST  = SCALE_LOG2'(SCALE - 1);
    localparam logic [ADDR_W-1:0]     FB_W_A    = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0]     FB_SIZE_A = ADDR_W'(FB_W * FB_H);
    localparam logic [FW-1:0]         LOW_WM_F  = FW'(LOW_WM);
    localparam logic [FW-1:0]         DEPTH_F   = FW'(FIFO_DEPTH);

    logic [FXW-1:0]        fx;
    logic [FYW-1:0]        fy;
    logic [SCALE_LOG2-1:0] rep;
    logic [SCALE_LOG2-1:0] sx;
    logic [ADDR_W-1:0]     line_base;
    logic [ADDR_W-1:0]     vid_addr;
    logic                  done;

    logic                  rd_bus;
    logic                  rd_pend;
    logic                  cpu_rd_bus;
    logic [FW-1:0]         fill;

    logic                  vid_ok;
    logic                  cpu_ok;
    logic                  sel_vid;
    logic                  sel_cpu;
    logic                  cpu_is_wr;
    logic                  cpu_in_range;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic [11:0]           fifo_head;
    logic [CW-1:0]         fifo_count;

    vga_fb_fifo #(
        .W     (12),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_25   (clk_25),
        .rst_n    (rst_n),
        .flush    (frame_start),
        .push_vld (fifo_push),
        .push_dat (ram_rdata),
        .pop_rdy  (fifo_pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // rd_bus: read on ram_addr now; rd_pend: its data is on ram_rdata now.
    assign fill         = FW'(fifo_count) + FW'(rd_bus) + FW'(rd_pend);
    assign vid_addr     = line_base + ADDR_W'(fx);
    assign cpu_in_range = (cpu_addr < FB_SIZE_A);
    assign fifo_push    = rd_pend && !frame_start;
    assign fifo_pop     = pix_rd && (sx == REP_LAST) && !frame_start;
    assign pix_rgb      = fifo_empty ? 12'h000 : fifo_head;

`ifdef VGA_FB_CPU_READ_EN
    assign cpu_is_wr = cpu_we;
`else
    assign cpu_is_wr = 1'b1;
`endif

    // Video is held off during frame_start so nothing issued with stale counters can reach the FIFO.
    always_comb begin
        vid_ok  = !done && !frame_start;
        cpu_ok  = cpu_req && !cpu_ack && !cpu_rd_bus;
        sel_vid = 1'b0;
        sel_cpu = 1'b0;
        if (vid_ok && (fill < LOW_WM_F)) begin
            sel_vid = 1'b1;
        end else if (cpu_ok) begin
            sel_cpu = 1'b1;
        end else if (vid_ok && (fill < DEPTH_F)) begin
            sel_vid = 1'b1;
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            cpu_ack    <= 1'b0;
            cpu_rd_bus <= 1'b0;
            rd_bus     <= 1'b0;
            rd_pend    <= 1'b0;
            fx         <= '0;
            fy         <= '0;
            rep        <= '0;
            line_base  <= '0;
            done       <= 1'b0;
        end else begin
            ram_we     <= sel_cpu && cpu_is_wr && cpu_in_range;
            cpu_ack    <= (sel_cpu && cpu_is_wr) || cpu_rd_bus;
            cpu_rd_bus <= sel_cpu && !cpu_is_wr;
            rd_bus     <= sel_vid;
            rd_pend    <= rd_bus && !frame_start;

            if (sel_vid) begin
                ram_addr <= vid_addr;
                if (fx == FX_LAST) begin
                    fx <= '0;
                    if (rep == REP_LAST) begin
                        rep <= '0;
                        if (fy == FY_LAST) begin
                            done <= 1'b1;
                        end else begin
                            fy        <= fy + 1'b1;
                            line_base <= line_base + FB_W_A;
                        end
                    end else begin
                        rep <= rep + 1'b1;
                    end
                end else begin
                    fx <= fx + 1'b1;
                end
            end else if (sel_cpu) begin
                ram_addr  <= cpu_addr;
                ram_wdata <= cpu_data;
            end

            if (frame_start) begin
                fx        <= '0;
                fy        <= '0;
                rep       <= '0;
                line_base <= '0;
                done      <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            sx        <= '0;
            underflow <= 1'b0;
        end else begin
            if (frame_start) sx <= '0;
            else if (pix_rd) sx <= sx + 1'b1;
            if (pix_rd && fifo_empty) underflow <= 1'b1;
        end
    end

`ifdef VGA_FB_CPU_READ_EN
    logic        cpu_rd_pend;
    logic        cpu_rd_oor;
    logic [11:0] cpu_rdata_q;
    logic [11:0] cpu_rd_val;

    assign cpu_rd_val = cpu_rd_oor ? 12'h000 : ram_rdata;
    assign cpu_rdata  = cpu_rd_pend ? cpu_rd_val : cpu_rdata_q;

    // Grants are blocked while a read is outstanding, so the range flag is stable until its ack.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rd_pend <= 1'b0;
            cpu_rd_oor  <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            cpu_rd_pend <= cpu_rd_bus;
            if (sel_cpu && !cpu_is_wr) cpu_rd_oor <= !cpu_in_range;
            if (cpu_rd_pend) cpu_rdata_q <= cpu_rd_val;
        end
    end
`endif
endmodule

// File: tb/tb_vga_fb_scanout_arbiter.sv
// Directed bench: a RAM model behind the DUT, expected values queued by the stimulus
// and compared by a negedge monitor.
module tb_vga_fb_scanout_arbiter;
    localparam int FB_SIZE = 19200;

    localparam int P_ADDR = 0;
    localparam int P_WE   = 1;
    localparam int P_ACK  = 2;
    localparam int P_UF   = 3;
    localparam int P_PIX  = 4;
    localparam int P_ACKN = 5;
    localparam int P_WEN  = 6;
    localparam int P_DBL  = 7;
    localparam int P_MEM  = 8;
    localparam int P_QLEN = 9;

    logic        clk_25 = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_rd = 1'b0;
    logic [11:0] pix_rgb;
    logic        underflow;
    logic        cpu_req = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [11:0] cpu_data = '0;
    logic        cpu_ack;
    logic [14:0] ram_addr;
    logic [11:0] ram_wdata;
    logic        ram_we;
    logic [11:0] ram_rdata = '0;
`ifdef VGA_FB_CPU_READ_EN
    logic        cpu_we = 1'b1;
    logic [11:0] cpu_rdata;
`endif

    vga_fb_scanout_arbiter dut (
        .clk_25      (clk_25),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_rd      (pix_rd),
        .pix_rgb     (pix_rgb),
        .underflow   (underflow),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
`ifdef VGA_FB_CPU_READ_EN
        .cpu_we      (cpu_we),
        .cpu_rdata   (cpu_rdata),
`endif
        .cpu_ack     (cpu_ack),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_rdata   (ram_rdata)
    );

    always #20 clk_25 = ~clk_25;

    logic [11:0] mem [FB_SIZE];

    always @(posedge clk_25) begin
        if (ram_we && int'(ram_addr) < FB_SIZE) mem[ram_addr] <= ram_wdata;
        ram_rdata <= (int'(ram_addr) < FB_SIZE) ? mem[ram_addr] : 12'h000;
    end

    typedef struct {
        int    id;
        int    exp;
        string name;
    } chk_t;

    chk_t        chk_q[$];
    logic [11:0] exp_pix[$];
    logic        sb_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt = 0;
    int we_cnt  = 0;
    int dbl_cnt = 0;
    logic ack_prev = 1'b0;

    function automatic int probe(input int id);
        case (id)
            P_ADDR:  return int'(ram_addr);
            P_WE:    return int'(ram_we);
            P_ACK:   return int'(cpu_ack);
            P_UF:    return int'(underflow);
            P_PIX:   return int'(pix_rgb);
            P_ACKN:  return ack_cnt;
            P_WEN:   return we_cnt;
            P_DBL:   return dbl_cnt;
            P_MEM:   return int'(mem[256]);
            P_QLEN:  return exp_pix.size();
            default: return -1;
        endcase
    endfunction

    task automatic expect_now(input int id, input int exp, input string name);
        chk_t c;
        c.id   = id;
        c.exp  = exp;
        c.name = name;
        chk_q.push_back(c);
    endtask

    task automatic tick;
        @(posedge clk_25);
        #1;
    endtask

    always @(negedge clk_25) begin : monitor
        chk_t        c;
        int          act;
        logic [11:0] e;
        if (cpu_ack) ack_cnt++;
        if (cpu_ack && ack_prev) dbl_cnt++;
        if (ram_we) we_cnt++;
        ack_prev = cpu_ack;
        if (rst_n && sb_en && pix_rd) begin
            n_tests++;
            if (exp_pix.size() == 0) begin
                n_fail++;
                $display("FAIL pix_sb: pixel 0x%03h presented with no expected entry", pix_rgb);
            end else begin
                e = exp_pix.pop_front();
                if (pix_rgb !== e) begin
                    n_fail++;
                    $display("FAIL pix_sb: got 0x%03h, expected 0x%03h at %0t", pix_rgb, e, $time);
                end
            end
        end
        while (chk_q.size() > 0) begin
            c   = chk_q.pop_front();
            act = probe(c.id);
            n_tests++;
            if (act != c.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, act, c.exp);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_base;
        int we_base;
        for (int i = 0; i < FB_SIZE; i++) mem[i] <= 12'(i);
        mem[0] <= 12'h5A5;

        // Reset state and initial prefetch
        repeat (2) tick;
        expect_now(P_ADDR, 0, "rst_ram_addr");
        expect_now(P_WE,   0, "rst_ram_we");
        expect_now(P_ACK,  0, "rst_cpu_ack");
        expect_now(P_UF,   0, "rst_underflow");
        expect_now(P_PIX,  0, "rst_pix_rgb");
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            expect_now(P_ADDR, i, "prefetch_addr");
        end
        repeat (12) tick;
        expect_now(P_ADDR, 7, "prefetch_stop_addr");
        expect_now(P_WE,   0, "prefetch_stop_we");
        expect_now(P_PIX,  12'h5A5, "prefetch_head");
        expect_now(P_UF,   0, "prefetch_uf");
        tick;

        // Scanout of 12 display lines, CPU writes held through line 8
        mem[0] <= 12'h000;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        repeat (20) tick;
        sb_en = 1'b1;
        ack_base = 0;
        for (int ln = 0; ln < 12; ln++) begin
            if (ln == 8) begin
                cpu_addr = 15'h0100;
                cpu_data = 12'hABC;
                cpu_req  = 1'b1;
                ack_base = ack_cnt;
            end
            for (int px = 0; px < 640; px++) begin
                pix_rd = 1'b1;
                exp_pix.push_back(12'((ln >> 2) * 160 + (px >> 2)));
                tick;
            end
            pix_rd = 1'b0;
            if (ln == 8) cpu_req = 1'b0;
            repeat (160) tick;
            if (ln == 8) begin
                expect_now(P_ACKN, ack_base + 320, "cpu_ack_count");
                expect_now(P_DBL,  0, "cpu_ack_back_to_back");
                expect_now(P_MEM,  12'hABC, "cpu_write_mem");
            end
        end
        expect_now(P_UF,   0, "scan_underflow");
        expect_now(P_QLEN, 0, "scan_all_pixels_seen");
        tick;
        sb_en = 1'b0;

        // Out-of-range CPU write
        ack_base = ack_cnt;
        we_base  = we_cnt;
        cpu_addr = 15'd19200;
        cpu_data = 12'h123;
        cpu_req  = 1'b1;
        for (int t = 0; t < 50 && ack_cnt == ack_base; t++) tick;
        cpu_req = 1'b0;
        repeat (5) tick;
        expect_now(P_ACKN, ack_base + 1, "oor_ack_once");
        expect_now(P_WEN,  we_base, "oor_no_we");
        tick;

        // Underflow straight out of reset
        rst_n = 1'b0;
        repeat (2) tick;
        rst_n  = 1'b1;
        pix_rd = 1'b1;
        expect_now(P_PIX, 0, "uf_pix_c0");
        expect_now(P_UF,  0, "uf_before");
        tick;
        expect_now(P_PIX, 0, "uf_pix_c1");
        expect_now(P_UF,  1, "uf_set");
        tick;
        expect_now(P_PIX, 0, "uf_pix_c2");
        repeat (38) tick;
        pix_rd = 1'b0;
        repeat (20) tick;

        // frame_start while a fetched read is in flight
        mem[0] <= 12'h5A5;
        mem[1] <= 12'h5A6;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        expect_now(P_UF,  1, "uf_sticky_after_fs");
        expect_now(P_PIX, 0, "fs_flushed");
        tick;
        expect_now(P_ADDR, 0, "fs_first_read");
        tick;
        frame_start = 1'b1;
        expect_now(P_ADDR, 1, "fs_second_read");
        tick;
        frame_start = 1'b0;
        expect_now(P_PIX,  0, "fs_discard_empty");
        expect_now(P_ADDR, 1, "fs_idle_hold");
        expect_now(P_WE,   0, "fs_idle_we");
        tick;
        expect_now(P_ADDR, 0, "fs_restart_addr0");
        tick;
        expect_now(P_PIX, 0, "fs_still_empty");
        tick;
        expect_now(P_PIX, 12'h5A5, "fs_head_after_restart");
        repeat (2) tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
